rate_tick_gen: RTL



---
 rtl/clk_div_pkg.sv | 77 +++++++
 rtl/rate_sel_enc.sv | 82 ++++++++
 rtl/rate_tick_gen.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and elaboration-time helpers for decade-spaced rate dividers.
// Latency: none; only constant functions, types and a configuration-check macro.
// Backpressure: none; nothing in here carries traffic.
//
// Contents:
//   rate_idx_t          container type for a rate index (wide enough for any sane NUM_RATES)
//   tick_state_e        IDLE / RUN state of a tick generator
//   pow_int()           integer power, evaluated at elaboration
//   half_period()       clk_hz / (2 * base_hz * step^k)
//   hp_exact()          true when that division is exact and the result is >= 1
//   all_rates_exact()   hp_exact() over every rate index
//   CLK_DIV_ELAB_CHECK  generate-time guard that stops elaboration on a bad configuration

`define CLK_DIV_ELAB_CHECK(cond, msg) \
  if (!(cond)) begin : g_clk_div_elab_fail \
    $error(msg); \
  end

package clk_div_pkg;

  localparam int unsigned RATE_IDX_MAX_W = 8;

  typedef logic [RATE_IDX_MAX_W-1:0] rate_idx_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tick_state_e;

  function automatic longint unsigned pow_int(input int unsigned base, input rate_idx_t exp);
    longint unsigned r;
    int unsigned     n;
    r = 64'd1;
    n = 32'(exp);
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'(base);
    end
    return r;
  endfunction

  // Denominator of the half-period division; 0 flags an unusable configuration.
  function automatic longint unsigned hp_den(input int unsigned base_hz, input int unsigned step,
                                             input rate_idx_t k);
    return 64'd2 * 64'(base_hz) * pow_int(step, k);
  endfunction

  function automatic int unsigned half_period(input int unsigned clk_hz, input int unsigned base_hz,
                                              input int unsigned step, input rate_idx_t k);
    longint unsigned den;
    den = hp_den(base_hz, step, k);
    if (den == 64'd0) begin
      return 32'd0;
    end
    return 32'(64'(clk_hz) / den);
  endfunction

  function automatic bit hp_exact(input int unsigned clk_hz, input int unsigned base_hz,
                                  input int unsigned step, input rate_idx_t k);
    longint unsigned den;
    den = hp_den(base_hz, step, k);
    if (den == 64'd0) begin
      return 1'b0;
    end
    return ((64'(clk_hz) % den) == 64'd0) && ((64'(clk_hz) / den) >= 64'd1);
  endfunction

  function automatic bit all_rates_exact(input int unsigned clk_hz, input int unsigned base_hz,
                                         input int unsigned step, input int unsigned num_rates);
    for (int unsigned k = 0; k < num_rates; k++) begin
      if (!hp_exact(clk_hz, base_hz, step, rate_idx_t'(k))) begin
        return 1'b0;
      end
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/rate_sel_enc.sv
// Rate request decoder: optional input synchroniser, priority encode, registered index.
// Latency: 1 cycle rate_req->req_idx; with RATE_TICK_SYNC_EN, 3 cycles (and en delayed 2).
// Backpressure: none; the index simply follows the switches, the consumer picks its moment.
//
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   en_i             run enable from the board
//   rate_req_i       speed-up switches; bit k-1 requests rate k, highest set bit wins
//   en_o             enable as seen by the consumer (synchronised when the macro is defined)
//   req_idx_o        registered requested rate index (0 when no switch is set)
//
// Build option: RATE_TICK_SYNC_EN adds a 2-flop synchroniser on en_i and rate_req_i.

module rate_sel_enc
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_RATES = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         en_i,
  input  logic [NUM_RATES-2:0]         rate_req_i,
  output logic                         en_o,
  output logic [$clog2(NUM_RATES)-1:0] req_idx_o
);

  localparam int unsigned IDX_W = $clog2(NUM_RATES);

  logic [NUM_RATES-2:0] req_in;
  logic [IDX_W-1:0]     req_idx_d;
  logic [IDX_W-1:0]     req_idx_q;

`ifdef RATE_TICK_SYNC_EN
  // Switches and enable come straight off the board; two flops settle metastability.
  logic [NUM_RATES-2:0] req_meta_q;
  logic [NUM_RATES-2:0] req_sync_q;
  logic                 en_meta_q;
  logic                 en_sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      req_meta_q <= '0;
      req_sync_q <= '0;
      en_meta_q  <= 1'b0;
      en_sync_q  <= 1'b0;
    end else begin
      req_meta_q <= rate_req_i;
      req_sync_q <= req_meta_q;
      en_meta_q  <= en_i;
      en_sync_q  <= en_meta_q;
    end
  end

  assign req_in = req_sync_q;
  assign en_o   = en_sync_q;
`else
  // Inputs are already debounced and synchronous to clk_i.
  assign req_in = rate_req_i;
  assign en_o   = en_i;
`endif

  // Ascending scan so the highest set switch overwrites lower ones.
  always_comb begin
    req_idx_d = '0;
    for (int unsigned k = 1; k < NUM_RATES; k++) begin
      if (req_in[k-1]) begin
        req_idx_d = IDX_W'(k);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      req_idx_q <= '0;
    end else begin
      req_idx_q <= req_idx_d;
    end
  end

  assign req_idx_o = req_idx_q;

endmodule

// File: rtl/rate_tick_gen.sv
// Decade-spaced rate generator: 50% square wave plus one-cycle tick enable at the active rate.
// Latency: first tick HP[rate] cycles after en is sampled high; rate switches only at a falling edge.
// Backpressure: none; tick is a free-running enable, rate requests wait for the next period boundary.
//
// Ports:
//   clk       system clock, all logic on its rising edge
//   rst_n     asynchronous active-low reset
//   en        run enable; low holds clk_hz and tick low and the counter at 0
//   rate_req  speed-up switches; bit k-1 requests rate k, highest set bit wins, none -> rate 0
//   clk_hz    registered 50% square wave at the active rate
//   tick      one-cycle pulse in the first cycle clk_hz is high
//   rate_cur  index of the active rate
//   rate_chg  one-cycle pulse in the cycle rate_cur takes a new value
//
// Build option: RATE_TICK_SYNC_EN synchronises en and rate_req inside rate_sel_enc.

module rate_tick_gen
  import clk_div_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned BASE_HZ   = 1,
  parameter int unsigned RATE_STEP = 10,
  parameter int unsigned NUM_RATES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [NUM_RATES-2:0]         rate_req,
  output logic                         clk_hz,
  output logic                         tick,
  output logic [$clog2(NUM_RATES)-1:0] rate_cur,
  output logic                         rate_chg
);

  localparam int unsigned IDX_W = $clog2(NUM_RATES);
  localparam int unsigned HP0   = half_period(CLK_HZ, BASE_HZ, RATE_STEP, rate_idx_t'(0));
  // Rate 0 is the slowest, so its half-period sizes the shared counter.
  localparam int unsigned CNT_W = (HP0 > 1) ? $clog2(HP0) : 1;

  localparam bit CFG_OK = (NUM_RATES >= 2) &&
                          (NUM_RATES <= (1 << RATE_IDX_MAX_W)) &&
                          all_rates_exact(CLK_HZ, BASE_HZ, RATE_STEP, NUM_RATES);

  `CLK_DIV_ELAB_CHECK(CFG_OK, "rate_tick_gen: every half-period must be an exact integer >= 1")

  // Terminal count (HP-1) for each rate, folded to constants.
  logic [CNT_W-1:0] hp_last [NUM_RATES];

  for (genvar k = 0; k < NUM_RATES; k++) begin : g_hp
    localparam int unsigned HP_K = half_period(CLK_HZ, BASE_HZ, RATE_STEP, rate_idx_t'(k));
    assign hp_last[k] = CNT_W'(HP_K - 32'd1);
  end

  // Request decode
  logic             en_s;
  logic [IDX_W-1:0] req_idx;

  rate_sel_enc #(
    .NUM_RATES (NUM_RATES)
  ) u_rate_sel_enc (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .en_i       (en),
    .rate_req_i (rate_req),
    .en_o       (en_s),
    .req_idx_o  (req_idx)
  );

  tick_state_e      state_q;
  tick_state_e      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             clk_hz_q;
  logic             clk_hz_d;
  logic             tick_q;
  logic             tick_d;
  logic [IDX_W-1:0] rate_cur_q;
  logic [IDX_W-1:0] rate_cur_d;
  logic             rate_chg_q;
  logic             rate_chg_d;

  logic             chg_pend;
  logic             at_last;

  assign chg_pend = (req_idx != rate_cur_q);
  assign at_last  = (cnt_q == hp_last[rate_cur_q]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: the state is just the enable delayed by one cycle, which is what
  // gives the counter its clean zero start on the cycle after en rises.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en_s)  state_d = ST_RUN;
      ST_RUN:  if (!en_s) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next-state logic
  always_comb begin
    cnt_d      = cnt_q;
    clk_hz_d   = clk_hz_q;
    tick_d     = 1'b0;
    rate_cur_d = rate_cur_q;
    rate_chg_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Nothing is being generated, so a new rate can be taken without a runt.
        cnt_d    = '0;
        clk_hz_d = 1'b0;
        if (chg_pend) begin
          rate_cur_d = req_idx;
          rate_chg_d = 1'b1;
        end
      end

      ST_RUN: begin
        if (!en_s) begin
          // Enable dropped mid-period: stop immediately, no tick.
          cnt_d    = '0;
          clk_hz_d = 1'b0;
        end else if (at_last) begin
          cnt_d    = '0;
          clk_hz_d = ~clk_hz_q;
          if (!clk_hz_q) begin
            tick_d = 1'b1;
          end else if (chg_pend) begin
            // Falling edge is the only point a running output may change rate; the
            // counter restart above makes the new low phase full length.
            rate_cur_d = req_idx;
            rate_chg_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        cnt_d    = '0;
        clk_hz_d = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      clk_hz_q   <= 1'b0;
      tick_q     <= 1'b0;
      rate_cur_q <= '0;
      rate_chg_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      clk_hz_q   <= clk_hz_d;
      tick_q     <= tick_d;
      rate_cur_q <= rate_cur_d;
      rate_chg_q <= rate_chg_d;
    end
  end

  assign clk_hz   = clk_hz_q;
  assign tick     = tick_q;
  assign rate_cur = rate_cur_q;
  assign rate_chg = rate_chg_q;

endmodule
